// File: rtl/alu_if.sv
// Execute-stage bundle between decode and the ALU: operand/op selects in,
// combinational results and the registered fault flag out.
interface alu_if;
  logic [2:0]  alu_op;
  logic [1:0]  addr_alu_op;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] pc;
  logic [2:0]  funct3;
  logic [31:0] alu_out;
  logic [31:0] addr_alu_out;
  logic        fault;

  modport master (
    output alu_op, addr_alu_op, imm, rs1, rs2, pc, funct3,
    input  alu_out, addr_alu_out, fault
  );

  modport slave (
    input  alu_op, addr_alu_op, imm, rs1, rs2, pc, funct3,
    output alu_out, addr_alu_out, fault
  );
endinterface

// File: rtl/alu_unit.sv
// RV32I execute datapath: result ALU and address adder (both combinational)
// plus a one-cycle-late illegal-encoding flag.
module alu_unit (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);
  typedef enum logic [2:0] {
    OP_LUI  = 3'd0,
    OP_LINK = 3'd1,
    OP_AUI  = 3'd2,
    OP_RSV3 = 3'd3,
    OP_ST   = 3'd4,
    OP_IMM  = 3'd5,
    OP_REG  = 3'd6,
    OP_RSV7 = 3'd7
  } alu_op_e;

  // funct7 lives in imm[11:5]; bit 10 selects sub/sra variants.
  logic [6:0]  f7;
  logic        alt;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [31:0] res;
  logic [31:0] addr;
  logic        illegal;
  logic        fault_q;
  alu_op_e     op;

  assign op    = alu_op_e'(bus.alu_op);
  assign f7    = bus.imm[11:5];
  assign alt   = bus.imm[10];
  assign b     = (op == OP_REG) ? bus.rs2 : bus.imm;
  assign shamt = b[4:0];

  always_comb begin
    res = '0;
    unique case (op)
      OP_LUI:  res = bus.imm;
      OP_LINK: res = bus.pc + 32'd4;
      OP_AUI:  res = bus.pc + bus.imm;
      OP_ST:   res = bus.rs2;
      OP_IMM, OP_REG: begin
        unique case (bus.funct3)
          3'd0: res = (op == OP_REG && alt) ? bus.rs1 - b : bus.rs1 + b;
          3'd1: res = bus.rs1 << shamt;
          3'd2: res = {31'd0, $signed(bus.rs1) < $signed(b)};
          3'd3: res = {31'd0, bus.rs1 < b};
          3'd4: res = bus.rs1 ^ b;
          3'd5: res = alt ? 32'($signed(bus.rs1) >>> shamt) : bus.rs1 >> shamt;
          3'd6: res = bus.rs1 | b;
          default: res = bus.rs1 & b;
        endcase
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    addr = bus.pc;
    unique case (bus.addr_alu_op)
      2'd0: addr = bus.pc;
      2'd1: addr = bus.pc + bus.imm;
      2'd2: addr = bus.rs1 + bus.imm;
      default: addr = (bus.rs1 + bus.imm) & ~32'h1;
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    unique case (op)
      OP_RSV3, OP_RSV7: illegal = 1'b1;
      OP_IMM: begin
        if (bus.funct3 == 3'd1 && f7 != 7'h00) illegal = 1'b1;
        if (bus.funct3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) illegal = 1'b1;
      end
      OP_REG: begin
        if (f7 != 7'h00 && f7 != 7'h20) illegal = 1'b1;
        if (f7 == 7'h20 && bus.funct3 != 3'd0 && bus.funct3 != 3'd5) illegal = 1'b1;
      end
      default: illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= illegal;
  end

  assign bus.alu_out      = res;
  assign bus.addr_alu_out = addr;
  assign bus.fault        = fault_q;
endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: hand-computed vectors for both ALUs and the
// registered fault flag, including async reset while the flag is high.
module tb_alu_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_if bus ();

  alu_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] f3, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] im);
    bus.alu_op = op;
    bus.funct3 = f3;
    bus.rs1    = r1;
    bus.rs2    = r2;
    bus.imm    = im;
    #1;
  endtask

  initial begin
    bus.alu_op = 3'd0; bus.addr_alu_op = 2'd0; bus.imm = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.pc = '0; bus.funct3 = '0;
    #2;
    chk("reset_fault", {31'd0, bus.fault}, 32'd0);
    // outputs follow inputs during reset
    drive(3'd0, 3'd0, 32'd0, 32'd0, 32'hFF);
    chk("lui_in_reset", bus.alu_out, 32'hFF);
    @(negedge clk); rst_n = 1'b1;

    bus.pc = 32'd4;
    drive(3'd1, 3'd0, 32'd0, 32'd0, 32'd0);          chk("link", bus.alu_out, 32'd8);
    drive(3'd2, 3'd0, 32'd0, 32'd0, 32'h10);         chk("auipc", bus.alu_out, 32'h14);
    drive(3'd4, 3'd0, 32'd0, 32'hBB, 32'd0);         chk("store", bus.alu_out, 32'hBB);
    drive(3'd5, 3'd0, 32'h10, 32'd0, 32'h22);        chk("addi", bus.alu_out, 32'h32);
    drive(3'd5, 3'd2, 32'd1, 32'd0, 32'hFFFFFFFF);   chk("slti", bus.alu_out, 32'd0);
    drive(3'd5, 3'd3, 32'd1, 32'd0, 32'hFFFFFFFF);   chk("sltiu", bus.alu_out, 32'd1);
    drive(3'd5, 3'd4, 32'd2, 32'd0, 32'd3);          chk("xori", bus.alu_out, 32'd1);
    drive(3'd5, 3'd6, 32'd2, 32'd0, 32'd3);          chk("ori", bus.alu_out, 32'd3);
    drive(3'd5, 3'd7, 32'd2, 32'd0, 32'd3);          chk("andi", bus.alu_out, 32'd2);
    drive(3'd5, 3'd5, 32'hFFFFFFFF, 32'd0, 32'h010); chk("srli", bus.alu_out, 32'h0000FFFF);
    drive(3'd5, 3'd5, 32'hFFFFFFFF, 32'd0, 32'h410); chk("srai", bus.alu_out, 32'hFFFFFFFF);
    drive(3'd5, 3'd1, 32'd1, 32'd0, 32'd2);          chk("slli", bus.alu_out, 32'd4);
    drive(3'd6, 3'd0, 32'd1, 32'hFFFFFFFE, 32'h0);   chk("add_wrap", bus.alu_out, 32'hFFFFFFFF);
    drive(3'd6, 3'd0, 32'd1, 32'hFFFFFFFE, 32'h400); chk("sub", bus.alu_out, 32'd3);
    drive(3'd6, 3'd0, 32'hFFFFFFFF, 32'd1, 32'h0);   chk("add_ovf", bus.alu_out, 32'd0);
    drive(3'd6, 3'd5, 32'hFFFF0000, 32'hF0000010, 32'h0);   chk("srl", bus.alu_out, 32'h0000FFFF);
    drive(3'd6, 3'd5, 32'hFFFF0000, 32'hF0000010, 32'h400); chk("sra", bus.alu_out, 32'hFFFFFFFF);
    drive(3'd6, 3'd6, 32'hFFFF0000, 32'hF0000010, 32'h0);   chk("or", bus.alu_out, 32'hFFFF0010);
    drive(3'd6, 3'd7, 32'hFFFF0000, 32'hF0000010, 32'h0);   chk("and", bus.alu_out, 32'hF0000000);
    drive(3'd6, 3'd1, 32'd3, 32'h21, 32'h0);         chk("sll_shamt5", bus.alu_out, 32'd6);
    drive(3'd6, 3'd2, 32'hFFFFFFFF, 32'd0, 32'h0);   chk("slt", bus.alu_out, 32'd1);
    drive(3'd6, 3'd3, 32'hFFFFFFFF, 32'd0, 32'h0);   chk("sltu", bus.alu_out, 32'd0);
    drive(3'd7, 3'd0, 32'd5, 32'd5, 32'h5);          chk("op7_zero", bus.alu_out, 32'd0);

    bus.pc = 32'hF0;
    drive(3'd0, 3'd0, 32'd2, 32'd0, 32'd3);
    bus.addr_alu_op = 2'd0; #1; chk("addr_pc", bus.addr_alu_out, 32'hF0);
    bus.addr_alu_op = 2'd1; #1; chk("addr_br", bus.addr_alu_out, 32'hF3);
    bus.addr_alu_op = 2'd2; #1; chk("addr_rs1", bus.addr_alu_out, 32'h5);
    bus.addr_alu_op = 2'd3; #1; chk("addr_jalr", bus.addr_alu_out, 32'h4);
    bus.pc = 32'hFFFFFFFE; bus.imm = 32'd4;
    bus.addr_alu_op = 2'd1; #1; chk("addr_wrap", bus.addr_alu_out, 32'h2);

    // fault: one-cycle latency, not sticky
    @(negedge clk); drive(3'd7, 3'd0, 32'd0, 32'd0, 32'd0);
    chk("fault_pre_edge", {31'd0, bus.fault}, 32'd0);
    @(posedge clk); #1; chk("fault_op7", {31'd0, bus.fault}, 32'd1);
    @(negedge clk); drive(3'd5, 3'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1; chk("fault_clear", {31'd0, bus.fault}, 32'd0);
    @(negedge clk); drive(3'd5, 3'd1, 32'd1, 32'd0, 32'h400);
    @(posedge clk); #1; chk("fault_slli_f7", {31'd0, bus.fault}, 32'd1);
    @(negedge clk); drive(3'd5, 3'd5, 32'd1, 32'd0, 32'h410);
    @(posedge clk); #1; chk("srai_legal", {31'd0, bus.fault}, 32'd0);
    @(negedge clk); drive(3'd5, 3'd5, 32'd1, 32'd0, 32'h810);
    @(posedge clk); #1; chk("fault_srxi_f7", {31'd0, bus.fault}, 32'd1);
    @(negedge clk); drive(3'd6, 3'd0, 32'd1, 32'd1, 32'h020);
    @(posedge clk); #1; chk("fault_op_f7", {31'd0, bus.fault}, 32'd1);
    @(negedge clk); drive(3'd6, 3'd5, 32'd1, 32'd1, 32'h400);
    @(posedge clk); #1; chk("sra_legal", {31'd0, bus.fault}, 32'd0);
    @(negedge clk); drive(3'd6, 3'd1, 32'd1, 32'd1, 32'h400);
    @(posedge clk); #1; chk("fault_alt_f3", {31'd0, bus.fault}, 32'd1);
    @(negedge clk); drive(3'd3, 3'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1; chk("fault_op3", {31'd0, bus.fault}, 32'd1);

    // async reset while fault is high, then release with op still illegal
    @(negedge clk); #2; rst_n = 1'b0; #1;
    chk("fault_async_rst", {31'd0, bus.fault}, 32'd0);
    @(posedge clk); #1; chk("fault_held_rst", {31'd0, bus.fault}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; chk("fault_after_rel", {31'd0, bus.fault}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
